// File: rtl/text_line_fetcher.sv
// text_line_fetcher: per-scanline character fetch and pixel serializer.
// Text RAM codes and font rows are fetched three cycles per character into a
// one-entry holding register. The pixel shifter drains that register at PIX_EN.
module text_line_fetcher #(
  parameter int COLS   = 64,
  parameter int CHAR_W = 10,
  parameter int CHAR_H = 16,
  parameter int ADDR_W = 11
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LINE_START,
  input  logic [9:0]        LINE_NUM,
  input  logic              PIX_EN,
  output logic [ADDR_W-1:0] TXT_ADDR,
  input  logic [7:0]        TXT_DATA,
  output logic [7:0]        CHAR_OUT,
  output logic [3:0]        ROW_NUM,
  input  logic [CHAR_W-1:0] FONT_DATA,
  output logic              PIXEL_OUT,
  output logic              PIXEL_VALID,
  output logic              LINE_DONE,
  output logic              UNDERRUN
);

  // The column counters must be able to hold COLS itself ("line finished").
  localparam int COL_W = $clog2(COLS + 1);
  localparam int CNT_W = $clog2(CHAR_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RDCHAR,
    S_RDFONT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [ADDR_W-1:0]   r_row_base;
  logic [COL_W-1:0]    r_fetch_col;
  logic [COL_W-1:0]    r_pix_col;
  logic [ADDR_W-1:0]   r_txt_addr;
  logic [7:0]          r_char_out;
  logic [3:0]          r_row_num;
  logic [CHAR_W-1:0]   r_hold;
  logic                r_hold_valid;
  logic [CHAR_W-1:0]   r_shift;
  logic [CNT_W-1:0]    r_count;
  logic                r_pixel_out;
  logic                r_pixel_valid;
  logic                r_line_done;
  logic                r_underrun;

  logic [ADDR_W-1:0]   w_row_base;
  logic [3:0]          w_row_sel;
  logic [ADDR_W-1:0]   w_fetch_addr;
  logic                w_last_col;
  logic                w_issue;
  logic                w_rdfont;
  logic                w_load;
  logic                w_emit;
  logic                w_last_pix;
  logic                w_line_active;

  // Row base and font row derived from the scanline; base wraps in ADDR_W bits.
  assign w_row_base   = ADDR_W'((32'(LINE_NUM) / 32'(CHAR_H)) * 32'(COLS));
  assign w_row_sel    = 4'(32'(LINE_NUM) % 32'(CHAR_H));
  assign w_fetch_addr = r_row_base + ADDR_W'(r_fetch_col);
  assign w_last_col   = (32'(r_fetch_col) + 32'd1) >= 32'(COLS);

  // A fetch is only issued into an empty holding register, so the RDFONT write
  // and a shifter load (which needs a full register) never land together.
  assign w_issue  = (r_state == S_ISSUE) && !r_hold_valid;
  assign w_rdfont = (r_state == S_RDFONT);

  // Reload when empty, or on the edge that shifts out the final pixel so a
  // continuous PIX_EN stream sees no gap between characters.
  assign w_load        = r_hold_valid &&
                         ((r_count == '0) || (PIX_EN && (r_count == CNT_W'(1))));
  assign w_emit        = PIX_EN && (r_count != '0);
  assign w_last_pix    = w_emit && (r_count == CNT_W'(1));
  assign w_line_active = (r_state != S_IDLE) && (32'(r_pix_col) < 32'(COLS));

  assign TXT_ADDR    = r_txt_addr;
  assign CHAR_OUT    = r_char_out;
  assign ROW_NUM     = r_row_num;
  assign PIXEL_OUT   = r_pixel_out;
  assign PIXEL_VALID = r_pixel_valid;
  assign LINE_DONE   = r_line_done;
  assign UNDERRUN    = r_underrun;

  // Fetch FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Fetch FSM next state; LINE_START restarts from any state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   w_state_next = S_IDLE;
      S_ISSUE:  if (!r_hold_valid) w_state_next = S_RDCHAR;
      S_RDCHAR: w_state_next = S_RDFONT;
      S_RDFONT: w_state_next = w_last_col ? S_DONE : S_ISSUE;
      S_DONE:   w_state_next = S_DONE;
      default:  w_state_next = S_IDLE;
    endcase
    if (LINE_START) begin
      w_state_next = S_ISSUE;
    end
  end

  // Fetch datapath: row latch, text address, character code and column count.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_row_base  <= '0;
      r_row_num   <= '0;
      r_fetch_col <= '0;
      r_txt_addr  <= '0;
      r_char_out  <= '0;
    end else if (LINE_START) begin
      r_row_base  <= w_row_base;
      r_row_num   <= w_row_sel;
      r_fetch_col <= '0;
    end else begin
      if (w_issue) begin
        r_txt_addr <= w_fetch_addr;
      end
      if (r_state == S_RDCHAR) begin
        r_char_out <= TXT_DATA;
      end
      if (w_rdfont) begin
        r_fetch_col <= r_fetch_col + COL_W'(1);
      end
    end
  end

  // One-entry holding register between the font bus and the shifter.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
    end else if (LINE_START) begin
      r_hold_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_hold_valid <= 1'b0;
      end
      if (w_rdfont) begin
        r_hold       <= FONT_DATA;
        r_hold_valid <= 1'b1;
      end
    end
  end

  // Pixel shifter: load, MSB-first serialization, column tracking and flags.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_shift       <= '0;
      r_count       <= '0;
      r_pix_col     <= '0;
      r_pixel_out   <= 1'b0;
      r_pixel_valid <= 1'b0;
      r_line_done   <= 1'b0;
      r_underrun    <= 1'b0;
    end else if (LINE_START) begin
      r_shift       <= '0;
      r_count       <= '0;
      r_pix_col     <= '0;
      r_pixel_valid <= 1'b0;
      r_line_done   <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_pixel_valid <= 1'b0;
      r_line_done   <= 1'b0;
      if (w_emit) begin
        r_pixel_out   <= r_shift[CHAR_W-1];
        r_pixel_valid <= 1'b1;
        if (w_last_pix) begin
          r_pix_col <= r_pix_col + COL_W'(1);
          if (r_pix_col == COL_W'(COLS - 1)) begin
            r_line_done <= 1'b1;
          end
        end
      end else if (PIX_EN && !w_load) begin
        // Nothing to show: blank pixel, flagged only while the line is live.
        r_pixel_out <= 1'b0;
        if (w_line_active) begin
          r_pixel_valid <= 1'b1;
          r_underrun    <= 1'b1;
        end
      end
      if (w_load) begin
        r_shift <= r_hold;
        r_count <= CNT_W'(CHAR_W);
      end else if (w_emit) begin
        r_shift <= {r_shift[CHAR_W-2:0], 1'b0};
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_text_line_fetcher.sv
// Bench for text_line_fetcher: two instances (COLS=4 and COLS=64) share the
// control inputs; each has its own text RAM and font ROM model.
module tb_text_line_fetcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_start;
  logic [9:0]  line_num;
  logic        pix_en;
  bit          txt_mode;
  int          font_mode;
  bit          sel;

  logic [10:0] addr4, addr64;
  logic [7:0]  txt4, txt64, char4, char64;
  logic [3:0]  row4, row64;
  logic [9:0]  font4, font64;
  logic        pix4, pix64, pv4, pv64, done4, done64, und4, und64;

  int total = 0;
  int bad   = 0;

  // collector state
  int          n_valid, n_done, done_at, gaps;
  bit          prev_valid;
  logic [9:0]  word_sr;
  logic [31:0] last_addr;
  logic [31:0] addr_log[$];
  logic [9:0]  exp_word[64];

  always #5 clk = ~clk;

  text_line_fetcher #(.COLS(4), .CHAR_W(10), .CHAR_H(16), .ADDR_W(11)) u_dut4 (
    .CLK(clk), .RESET(rst_n), .LINE_START(line_start), .LINE_NUM(line_num),
    .PIX_EN(pix_en), .TXT_ADDR(addr4), .TXT_DATA(txt4), .CHAR_OUT(char4),
    .ROW_NUM(row4), .FONT_DATA(font4), .PIXEL_OUT(pix4), .PIXEL_VALID(pv4),
    .LINE_DONE(done4), .UNDERRUN(und4)
  );

  text_line_fetcher #(.COLS(64), .CHAR_W(10), .CHAR_H(16), .ADDR_W(11)) u_dut64 (
    .CLK(clk), .RESET(rst_n), .LINE_START(line_start), .LINE_NUM(line_num),
    .PIX_EN(pix_en), .TXT_ADDR(addr64), .TXT_DATA(txt64), .CHAR_OUT(char64),
    .ROW_NUM(row64), .FONT_DATA(font64), .PIXEL_OUT(pix64), .PIXEL_VALID(pv64),
    .LINE_DONE(done64), .UNDERRUN(und64)
  );

  // text RAM: data follows the address combinationally (valid next edge)
  assign txt4  = txt_mode ? addr4[7:0]  : 8'h48;
  assign txt64 = txt_mode ? addr64[7:0] : 8'h48;

  function automatic logic [9:0] font_func(input logic [7:0] ch, input logic [3:0] row,
                                           input int mode);
    if (mode == 1) return 10'h2AA;
    if (mode == 2) return {2'b10, ch};
    return (row == 4'd5) ? 10'h3FF : 10'h201;
  endfunction

  // font ROM updates on the falling edge
  always @(negedge clk) begin
    font4  <= font_func(char4, row4, font_mode);
    font64 <= font_func(char64, row64, font_mode);
  end

  logic        m_valid, m_pix, m_done, m_und;
  logic [10:0] m_addr;
  logic [3:0]  m_row;
  logic [7:0]  m_char;
  assign m_valid = sel ? pv64   : pv4;
  assign m_pix   = sel ? pix64  : pix4;
  assign m_done  = sel ? done64 : done4;
  assign m_und   = sel ? und64  : und4;
  assign m_addr  = sel ? addr64 : addr4;
  assign m_row   = sel ? row64  : row4;
  assign m_char  = sel ? char64 : char4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_col();
    n_valid    = 0;
    n_done     = 0;
    done_at    = -1;
    gaps       = 0;
    prev_valid = 1'b0;
    word_sr    = '0;
    addr_log.delete();
    last_addr  = 32'(m_addr);
  endtask

  task automatic run_cycles(input int n, input bit words);
    for (int i = 0; i < n; i++) begin
      tick();
      if (m_valid) begin
        if (!prev_valid && n_valid > 0) gaps++;
        word_sr = {word_sr[8:0], m_pix};
        n_valid++;
        if (words && (n_valid % 10 == 0) && (n_valid / 10 <= 64))
          chk($sformatf("word%0d", n_valid / 10 - 1), 32'(word_sr),
              32'(exp_word[n_valid / 10 - 1]));
      end
      if (m_done) begin
        n_done++;
        done_at = n_valid;
      end
      if (32'(m_addr) != last_addr) begin
        addr_log.push_back(32'(m_addr));
        last_addr = 32'(m_addr);
      end
      prev_valid = m_valid;
    end
  endtask

  task automatic start_line(input logic [9:0] ln, input bit s);
    sel        = s;
    line_num   = ln;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    clear_col();
  endtask

  task automatic check_addrs(input string tag, input int base, input int n);
    chk({tag, "_naddr"}, 32'(addr_log.size()), 32'(n));
    for (int i = 0; i < addr_log.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), addr_log[i], 32'(base + i));
  endtask

  task automatic fill_words(input int mode);
    for (int i = 0; i < 64; i++) begin
      if (mode == 0)      exp_word[i] = 10'h3FF;
      else if (mode == 1) exp_word[i] = 10'h2AA;
      else if (mode == 3) exp_word[i] = 10'h201;
      else                exp_word[i] = {2'b10, 8'(64 + i)};
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    line_start = 1'b0;
    line_num   = '0;
    pix_en     = 1'b0;
    txt_mode   = 1'b0;
    font_mode  = 0;
    sel        = 1'b0;
    tick();
    tick();
    chk("rst_outs4", {20'd0, pix4, pv4, done4, und4, row4, char4[3:0]}, 32'd0);
    chk("rst_addr4", 32'(addr4), 32'd0);
    chk("rst_outs64", {pix64, pv64, done64, und64, row64, char64, addr64}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Line 37 on 4 columns: base 8, row 5, all-ones font row
    fill_words(0);
    start_line(10'd37, 1'b0);
    run_cycles(3, 1'b1);
    pix_en = 1'b1;
    run_cycles(45, 1'b1);
    chk("t2_nvalid", 32'(n_valid), 32'd40);
    chk("t2_ndone", 32'(n_done), 32'd1);
    chk("t2_done_at", 32'(done_at), 32'd40);
    chk("t2_gaps", 32'(gaps), 32'd0);
    check_addrs("t2", 8, 4);
    chk("t2_row", 32'(m_row), 32'd5);
    chk("t2_char", 32'(m_char), 32'h48);
    chk("t2_und", 32'(m_und), 32'd0);
    chk("t2_after_valid", 32'(m_valid), 32'd0);
    pix_en = 1'b0;

    // Alternating font row, continuous PIX_EN from +4
    font_mode = 1;
    fill_words(1);
    start_line(10'd37, 1'b0);
    run_cycles(3, 1'b1);
    pix_en = 1'b1;
    run_cycles(45, 1'b1);
    chk("t3_nvalid", 32'(n_valid), 32'd40);
    chk("t3_gaps", 32'(gaps), 32'd0);
    chk("t3_done_at", 32'(done_at), 32'd40);
    chk("t3_und", 32'(m_und), 32'd0);
    pix_en = 1'b0;

    // Early PIX_EN at +2 -> underrun, sticky until next LINE_START
    start_line(10'd5, 1'b0);
    tick();
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    chk("t4_uvalid", 32'(m_valid), 32'd1);
    chk("t4_upix", 32'(m_pix), 32'd0);
    chk("t4_und", 32'(m_und), 32'd1);
    run_cycles(20, 1'b0);
    chk("t4_und_sticky", 32'(m_und), 32'd1);

    // Line 479 on 64 columns: base 1856, row 15, per-character fonts
    txt_mode  = 1'b1;
    font_mode = 2;
    fill_words(2);
    start_line(10'd479, 1'b1);
    chk("t6_und_clr", 32'(m_und), 32'd0);
    run_cycles(3, 1'b1);
    pix_en = 1'b1;
    run_cycles(645, 1'b1);
    chk("t6_nvalid", 32'(n_valid), 32'd640);
    chk("t6_ndone", 32'(n_done), 32'd1);
    chk("t6_done_at", 32'(done_at), 32'd640);
    chk("t6_gaps", 32'(gaps), 32'd0);
    check_addrs("t6", 1856, 64);
    chk("t6_row", 32'(m_row), 32'd15);
    chk("t6_after_valid", 32'(m_valid), 32'd0);
    chk("t6_und", 32'(m_und), 32'd0);
    pix_en = 1'b0;

    // Abort mid-line at pixel 15 and restart on line 16 (base 4, row 0)
    txt_mode  = 1'b0;
    font_mode = 0;
    fill_words(0);
    start_line(10'd37, 1'b0);
    tick();
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    tick();
    pix_en = 1'b1;
    clear_col();
    run_cycles(15, 1'b1);
    chk("t5_pre_nvalid", 32'(n_valid), 32'd14);
    chk("t5_pre_und", 32'(m_und), 32'd1);
    line_num   = 10'd16;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    pix_en     = 1'b0;
    chk("t5_und_clr", 32'(m_und), 32'd0);
    chk("t5_abort_valid", 32'(m_valid), 32'd0);
    chk("t5_pre_ndone", 32'(n_done), 32'd0);
    fill_words(3);
    clear_col();
    run_cycles(3, 1'b1);
    pix_en = 1'b1;
    run_cycles(45, 1'b1);
    chk("t5_nvalid", 32'(n_valid), 32'd40);
    chk("t5_ndone", 32'(n_done), 32'd1);
    chk("t5_done_at", 32'(done_at), 32'd40);
    check_addrs("t5", 4, 4);
    chk("t5_row", 32'(m_row), 32'd0);
    chk("t5_und", 32'(m_und), 32'd0);
    pix_en = 1'b0;

    // Reset asserted mid-line while in RDCHAR with the shifter loaded
    start_line(10'd37, 1'b0);
    run_cycles(3, 1'b0);
    pix_en = 1'b1;
    run_cycles(2, 1'b0);
    chk("t1_pre_valid", 32'(m_valid), 32'd1);
    chk("t1_pre_pix", 32'(m_pix), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_valid", 32'(m_valid), 32'd0);
    chk("t1_pix", 32'(m_pix), 32'd0);
    chk("t1_addr", 32'(m_addr), 32'd0);
    chk("t1_char_row", {20'd0, m_char, m_row}, 32'd0);
    run_cycles(3, 1'b0);
    chk("t1_hold_valid", 32'(m_valid), 32'd0);
    rst_n = 1'b1;
    run_cycles(3, 1'b0);
    chk("t1_idle_valid", 32'(m_valid), 32'd0);
    chk("t1_idle_und", 32'(m_und), 32'd0);
    chk("t1_idle_addr", 32'(m_addr), 32'd0);
    pix_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
